bomb_pool: RTL and testbench

Multi-slot bomb manager for the maze game. It holds up to NUM_BOMBS independent bombs, each running a fuse countdown and then a blast window on the game tick. It renders bomb and blast pixels for the current VGA scan coordinate, and supports an optional chain-reaction mode. It sits between the player-movement logic, which supplies position and the place request, and the VGA colour mux, which consumes the pixel flags.

---
 rtl/bomb_pool.sv | 191 +++++++++++++++++++
 tb/tb_bomb_pool.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_pool.sv
// Multi-slot bomb manager: per-slot fuse/blast countdown on the game tick,
// optional chain reaction, and registered bomb/blast pixel flags for the VGA mux.
module bomb_pool #(
  parameter int NUM_BOMBS   = 2,
  parameter int COORD_W     = 10,
  parameter int FUSE_TICKS  = 72,
  parameter int BLAST_TICKS = 24,
  parameter int BOMB_RAD    = 15,
  parameter int BLAST_HALF  = 22,
  parameter int BLINK_BIT   = 3,
  parameter int CHAIN_EN    = 1
) (
  input  logic                             board_clk,
  input  logic                             reset,
  input  logic                             tick,
  input  logic                             place,
  input  logic [COORD_W-1:0]               player_x,
  input  logic [COORD_W-1:0]               player_y,
  input  logic [COORD_W-1:0]               pix_x,
  input  logic [COORD_W-1:0]               pix_y,
  output logic                             bomb_pixel,
  output logic                             blast_pixel,
  output logic [$clog2(NUM_BOMBS+1)-1:0]   active_count,
  output logic                             pool_full,
  output logic                             place_ack,
  output logic                             explode
);

  localparam int MAX_TICKS = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam int ACT_W     = $clog2(NUM_BOMBS + 1);
  localparam int SQ_W      = 2 * COORD_W + 1;

  localparam logic [CNT_W-1:0]   FUSE_LOAD  = CNT_W'(FUSE_TICKS);
  localparam logic [CNT_W-1:0]   BLAST_LOAD = CNT_W'(BLAST_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [ACT_W-1:0]   ACT_ONE    = ACT_W'(1);
  localparam logic [COORD_W-1:0] HALF       = COORD_W'(BLAST_HALF);
  localparam logic [SQ_W-1:0]    RAD_SQ     = SQ_W'(BOMB_RAD * BOMB_RAD);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_FUSE, SLOT_BLAST} slot_state_e;

  slot_state_e        state_q [NUM_BOMBS];
  slot_state_e        state_d [NUM_BOMBS];
  logic [COORD_W-1:0] x_q     [NUM_BOMBS];
  logic [COORD_W-1:0] x_d     [NUM_BOMBS];
  logic [COORD_W-1:0] y_q     [NUM_BOMBS];
  logic [COORD_W-1:0] y_d     [NUM_BOMBS];
  logic [CNT_W-1:0]   cnt_q   [NUM_BOMBS];
  logic [CNT_W-1:0]   cnt_d   [NUM_BOMBS];

  logic             place_q, place_d;
  logic             bomb_pixel_q, bomb_pixel_d;
  logic             blast_pixel_q, blast_pixel_d;
  logic [ACT_W-1:0] active_count_q, active_count_d;
  logic             pool_full_q, pool_full_d;
  logic             place_ack_q, place_ack_d;
  logic             explode_q, explode_d;

  logic                 any_idle, dup_pos, accept, taken;
  logic [NUM_BOMBS-1:0] chain_hit;
  logic [COORD_W-1:0]   dx, dy;
  logic [SQ_W-1:0]      dist_sq;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic in_band(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                   input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
    return (abs_diff(ay, by) <= HALF) || (abs_diff(ax, bx) <= HALF);
  endfunction

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
        state_q[i] <= SLOT_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        cnt_q[i]   <= '0;
      end
      place_q        <= 1'b0;
      bomb_pixel_q   <= 1'b0;
      blast_pixel_q  <= 1'b0;
      active_count_q <= '0;
      pool_full_q    <= 1'b0;
      place_ack_q    <= 1'b0;
      explode_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      place_q        <= place_d;
      bomb_pixel_q   <= bomb_pixel_d;
      blast_pixel_q  <= blast_pixel_d;
      active_count_q <= active_count_d;
      pool_full_q    <= pool_full_d;
      place_ack_q    <= place_ack_d;
      explode_q      <= explode_d;
    end
  end

  // Placement and chain checks look only at slot state from the start of the tick.
  always_comb begin
    any_idle  = 1'b0;
    dup_pos   = 1'b0;
    chain_hit = '0;
    for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
      if (state_q[i] == SLOT_IDLE) any_idle = 1'b1;
      if (state_q[i] == SLOT_FUSE && x_q[i] == player_x && y_q[i] == player_y) dup_pos = 1'b1;
      for (int unsigned j = 0; j < NUM_BOMBS; j++) begin
        if (CHAIN_EN != 0 && state_q[j] == SLOT_BLAST &&
            in_band(x_q[i], y_q[i], x_q[j], y_q[j]))
          chain_hit[i] = 1'b1;
      end
    end

    accept      = tick && place && !place_q && any_idle && !dup_pos;
    taken       = 1'b0;
    explode_d   = 1'b0;
    place_ack_d = accept;
    place_d     = tick ? place : place_q;

    for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      cnt_d[i]   = cnt_q[i];
      if (tick) begin
        case (state_q[i])
          SLOT_IDLE: begin
            if (accept && !taken) begin
              taken      = 1'b1;
              state_d[i] = SLOT_FUSE;
              cnt_d[i]   = FUSE_LOAD;
              x_d[i]     = player_x;
              y_d[i]     = player_y;
            end
          end
          SLOT_FUSE: begin
            if (cnt_q[i] == CNT_ONE || chain_hit[i]) begin
              state_d[i] = SLOT_BLAST;
              cnt_d[i]   = BLAST_LOAD;
              explode_d  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
          end
          SLOT_BLAST: begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
            if (cnt_q[i] == CNT_ONE) state_d[i] = SLOT_IDLE;
          end
          default: state_d[i] = SLOT_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bomb_pixel_d   = 1'b0;
    blast_pixel_d  = 1'b0;
    active_count_d = '0;
    pool_full_d    = 1'b1;
    dx             = '0;
    dy             = '0;
    dist_sq        = '0;
    for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
      dx      = abs_diff(pix_x, x_q[i]);
      dy      = abs_diff(pix_y, y_q[i]);
      dist_sq = SQ_W'(dx) * SQ_W'(dx) + SQ_W'(dy) * SQ_W'(dy);
      if (state_q[i] == SLOT_FUSE && dist_sq < RAD_SQ && !cnt_q[i][BLINK_BIT])
        bomb_pixel_d = 1'b1;
      if (state_q[i] == SLOT_BLAST && in_band(pix_x, pix_y, x_q[i], y_q[i]))
        blast_pixel_d = 1'b1;
      if (state_d[i] != SLOT_IDLE) active_count_d = active_count_d + ACT_ONE;
      else pool_full_d = 1'b0;
    end
  end

  assign bomb_pixel   = bomb_pixel_q;
  assign blast_pixel  = blast_pixel_q;
  assign active_count = active_count_q;
  assign pool_full    = pool_full_q;
  assign place_ack    = place_ack_q;
  assign explode      = explode_q;

endmodule

// File: tb/tb_bomb_pool.sv
// Bench for bomb_pool: directed sequences, a pixel vector table, and randomized
// traffic checked every cycle against a timestamp-based reference model.
module tb_bomb_pool;

  localparam int NB    = 2;
  localparam int CW    = 10;
  localparam int FUSE  = 72;
  localparam int BLAST = 24;
  localparam int RAD   = 15;
  localparam int BH    = 22;
  localparam int BLINK = 3;
  localparam int ACW   = $clog2(NB + 1);

  logic clk;
  logic rst, tick, place;
  logic [CW-1:0] px, py, sx, sy;
  logic bomb_pixel, blast_pixel, pool_full, place_ack, explode;
  logic [ACW-1:0] active_count;
  logic nc_bomb_pixel, nc_blast_pixel, nc_pool_full, nc_place_ack, nc_explode;
  logic [ACW-1:0] nc_active_count;

  bomb_pool #(.NUM_BOMBS(NB), .COORD_W(CW), .FUSE_TICKS(FUSE), .BLAST_TICKS(BLAST),
              .BOMB_RAD(RAD), .BLAST_HALF(BH), .BLINK_BIT(BLINK), .CHAIN_EN(1)) dut (
    .board_clk(clk), .reset(rst), .tick(tick), .place(place),
    .player_x(px), .player_y(py), .pix_x(sx), .pix_y(sy),
    .bomb_pixel(bomb_pixel), .blast_pixel(blast_pixel), .active_count(active_count),
    .pool_full(pool_full), .place_ack(place_ack), .explode(explode));

  bomb_pool #(.NUM_BOMBS(NB), .COORD_W(CW), .FUSE_TICKS(FUSE), .BLAST_TICKS(BLAST),
              .BOMB_RAD(RAD), .BLAST_HALF(BH), .BLINK_BIT(BLINK), .CHAIN_EN(0)) dut_nc (
    .board_clk(clk), .reset(rst), .tick(tick), .place(place),
    .player_x(px), .player_y(py), .pix_x(sx), .pix_y(sy),
    .bomb_pixel(nc_bomb_pixel), .blast_pixel(nc_blast_pixel), .active_count(nc_active_count),
    .pool_full(nc_pool_full), .place_ack(nc_place_ack), .explode(nc_explode));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each bomb is a placement tick and a detonation tick;
  // its state at tick count mn follows from those timestamps.
  typedef struct {bit used; int p; int det; int x; int y;} mslot_t;
  mslot_t ms [NB];
  int     mn;
  bit     mplace;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int mstate(input int k);
    if (!ms[k].used) return 0;
    if (mn < ms[k].det) return 1;
    if (mn < ms[k].det + BLAST) return 2;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NB; k++) ms[k] = '{1'b0, 0, 0, 0, 0};
    mn = 0;
    mplace = 1'b0;
  endtask

  task automatic model_tick(output int ack, output int ex);
    int st [NB];
    int n1, free_k;
    bit hit, dup;
    n1 = mn + 1;
    for (int k = 0; k < NB; k++) st[k] = mstate(k);
    ex = 0;
    for (int k = 0; k < NB; k++) begin
      if (st[k] == 1) begin
        hit = 1'b0;
        for (int i = 0; i < NB; i++)
          if (st[i] == 2 && (iabs(ms[k].y - ms[i].y) <= BH || iabs(ms[k].x - ms[i].x) <= BH))
            hit = 1'b1;
        if (hit) ms[k].det = n1;
        if (ms[k].det == n1) ex = 1;
      end
    end
    ack = 0;
    if (place && !mplace) begin
      free_k = -1;
      dup = 1'b0;
      for (int k = 0; k < NB; k++) begin
        if (st[k] == 0 && free_k < 0) free_k = k;
        if (st[k] == 1 && ms[k].x == int'(px) && ms[k].y == int'(py)) dup = 1'b1;
      end
      if (free_k >= 0 && !dup) begin
        ms[free_k] = '{1'b1, n1, n1 + FUSE, int'(px), int'(py)};
        ack = 1;
      end
    end
    mplace = place;
    mn = n1;
  endtask

  // One clock with full model comparison of every output.
  task automatic cyc();
    int ebp, eblp, eack, eexp, ecnt, efull, s, dx, dy;
    ebp = 0;
    eblp = 0;
    if (!rst) begin
      for (int k = 0; k < NB; k++) begin
        s  = mstate(k);
        dx = iabs(int'(sx) - ms[k].x);
        dy = iabs(int'(sy) - ms[k].y);
        if (s == 1 && dx * dx + dy * dy < RAD * RAD &&
            (((ms[k].p + FUSE - mn) >> BLINK) & 1) == 0) ebp = 1;
        if (s == 2 && (dx <= BH || dy <= BH)) eblp = 1;
      end
    end
    @(posedge clk);
    #1;
    eack = 0;
    eexp = 0;
    if (rst) model_clear();
    else if (tick) model_tick(eack, eexp);
    ecnt = 0;
    for (int k = 0; k < NB; k++) if (mstate(k) != 0) ecnt++;
    efull = (ecnt == NB) ? 1 : 0;
    chk("m_bomb_pixel", bomb_pixel, ebp);
    chk("m_blast_pixel", blast_pixel, eblp);
    chk("m_place_ack", place_ack, eack);
    chk("m_explode", explode, eexp);
    chk("m_active_count", active_count, ecnt);
    chk("m_pool_full", pool_full, efull);
  endtask

  int ack_s, exp_s, nexp_s;

  task automatic tick1(input bit pl);
    tick = 1'b1;
    place = pl;
    cyc();
    ack_s = place_ack;
    exp_s = explode;
    nexp_s = nc_explode;
    tick = 1'b0;
    cyc();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bomb"}, bomb_pixel, 0);
    chk({tag, "_blast"}, blast_pixel, 0);
    chk({tag, "_cnt"}, active_count, 0);
    chk({tag, "_full"}, pool_full, 0);
    chk({tag, "_ack"}, place_ack, 0);
    chk({tag, "_expl"}, explode, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick = 1'b0;
    place = 1'b0;
    cyc();
    cyc();
    chk_zero("rst_hold");
    rst = 1'b0;
    cyc();
    chk_zero("rst_rel");
  endtask

  typedef struct {int x; int y; int blast; int bomb;} pv_t;
  pv_t pt [10];

  localparam int PSET_X [4] = '{100, 300, 600, 620};
  localparam int PSET_Y [4] = '{240, 250, 50, 400};

  int det_k, acks, d_e1, d_e2, n_e1, n_e2, ctr, bitv, sel;

  initial begin
    pt[0] = '{600, 240, 1, 0};
    pt[1] = '{100,  10, 1, 0};
    pt[2] = '{300, 400, 0, 0};
    pt[3] = '{100, 240, 1, 0};
    pt[4] = '{122, 400, 1, 0};
    pt[5] = '{123, 400, 0, 0};
    pt[6] = '{ 78, 400, 1, 0};
    pt[7] = '{ 77, 400, 0, 0};
    pt[8] = '{500, 262, 1, 0};
    pt[9] = '{500, 263, 0, 0};

    rst = 1'b1; tick = 1'b0; place = 1'b0;
    px = '0; py = '0; sx = '0; sy = '0;
    model_clear();

    // Single bomb: placement, fuse length, blast shape and duration.
    do_reset();
    px = 10'd100; py = 10'd240;
    tick1(1'b1);
    chk("a_ack", ack_s, 1);
    chk("a_cnt", active_count, 1);
    chk("a_ack_pulse_end", place_ack, 0);
    det_k = 0;
    for (int k = 1; k <= FUSE; k++) begin
      tick1(1'b0);
      if (exp_s == 1 && det_k == 0) det_k = k;
    end
    chk("a_det_tick", det_k, FUSE);
    for (int i = 0; i < 10; i++) begin
      sx = CW'(pt[i].x);
      sy = CW'(pt[i].y);
      cyc();
      chk($sformatf("a_tbl_blast%0d", i), blast_pixel, pt[i].blast);
      chk($sformatf("a_tbl_bomb%0d", i), bomb_pixel, pt[i].bomb);
    end
    sx = 10'd600; sy = 10'd240;
    for (int k = 1; k <= BLAST; k++) begin
      tick1(1'b0);
      if (k == BLAST - 1) begin
        chk("a_cnt_last_blast", active_count, 1);
        chk("a_pix_last_blast", blast_pixel, 1);
      end
    end
    chk("a_cnt_after_blast", active_count, 0);
    chk("a_pix_after_blast", blast_pixel, 0);

    // Pool full: third edge is refused.
    do_reset();
    px = 10'd100; py = 10'd240; tick1(1'b1); chk("b_ack1", ack_s, 1);
    tick1(1'b0);
    px = 10'd400; py = 10'd100; tick1(1'b1); chk("b_ack2", ack_s, 1);
    chk("b_full", pool_full, 1);
    tick1(1'b0);
    px = 10'd500; py = 10'd400; tick1(1'b1);
    chk("b_ack3", ack_s, 0);
    chk("b_full3", pool_full, 1);
    chk("b_cnt3", active_count, 2);

    // Held button gives one placement; same position again is refused.
    do_reset();
    px = 10'd100; py = 10'd240;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      tick1(1'b1);
      acks += ack_s;
    end
    chk("c_hold_acks", acks, 1);
    tick1(1'b0);
    tick1(1'b1);
    chk("c_dup_ack", ack_s, 0);
    chk("c_dup_cnt", active_count, 1);

    // Chain reaction vs independent detonation.
    do_reset();
    px = 10'd100; py = 10'd240; tick1(1'b1);
    for (int k = 2; k <= 10; k++) tick1(1'b0);
    px = 10'd300; py = 10'd250; tick1(1'b1);
    chk("d_ack_b", ack_s, 1);
    d_e1 = 0; d_e2 = 0; n_e1 = 0; n_e2 = 0;
    for (int t = 12; t <= 100; t++) begin
      tick1(1'b0);
      if (exp_s == 1) begin
        if (d_e1 == 0) d_e1 = t; else if (d_e2 == 0) d_e2 = t;
      end
      if (nexp_s == 1) begin
        if (n_e1 == 0) n_e1 = t; else if (n_e2 == 0) n_e2 = t;
      end
    end
    chk("d_chain_first", d_e1, 73);
    chk("d_chain_second", d_e2, 74);
    chk("d_nochain_first", n_e1, 73);
    chk("d_nochain_second", n_e2, 83);

    // Blink and disc radius.
    do_reset();
    px = 10'd200; py = 10'd200; tick1(1'b1);
    for (int k = 1; k <= 30; k++) begin
      tick1(1'b0);
      ctr  = FUSE - k;
      bitv = (ctr >> BLINK) & 1;
      sx = 10'd200; sy = 10'd200; cyc();
      chk("e_center", bomb_pixel, 1 - bitv);
      sx = 10'd210; sy = 10'd210; cyc();
      chk("e_off10", bomb_pixel, 1 - bitv);
      sx = 10'd211; sy = 10'd211; cyc();
      chk("e_off11", bomb_pixel, 0);
    end

    // Reset mid-blast with button held.
    do_reset();
    px = 10'd100; py = 10'd240; tick1(1'b1);
    for (int k = 0; k < FUSE + 5; k++) tick1(1'b0);
    chk("f_in_blast", active_count, 1);
    sx = 10'd100; sy = 10'd240;
    rst = 1'b1; place = 1'b1;
    cyc();
    chk_zero("f_rst");
    cyc();
    rst = 1'b0;
    cyc();
    chk_zero("f_rel");
    tick1(1'b1);
    chk("f_new_ack", ack_s, 1);
    chk("f_new_cnt", active_count, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 999) == 0);
      tick = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) place = ~place;
      if ($urandom_range(0, 7) == 0) begin
        sel = $urandom_range(0, 3);
        px = CW'(PSET_X[sel]);
        py = CW'(PSET_Y[sel]);
      end
      if ($urandom_range(0, 1) == 0) begin
        sx = CW'($urandom_range(0, 639));
        sy = CW'($urandom_range(0, 479));
      end else begin
        sel = $urandom_range(0, 3);
        sx = CW'(PSET_X[sel] + $urandom_range(0, 40) - 20);
        sy = CW'(PSET_Y[sel] + $urandom_range(0, 40) - 20);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
